// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter over 0..MAX with parallel load, wrap or saturate
// mode, a combinational terminal count for cascading and a registered wrap pulse.
module counter_updown_mod #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  input  logic             SAT,
  output logic [WIDTH-1:0] out,
  output logic             TC,
  output logic             WRAP
);

  if (WIDTH < 2 || WIDTH > 16 || MAX < 1 || MAX > (1 << WIDTH) - 1) begin : g_param_err
    $error("counter_updown_mod: WIDTH must be 2..16 and MAX must be 1..2^WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap_nxt;

  assign at_max  = (out == MAXV);
  assign at_zero = (out == '0);
  assign TC      = EN & ((UP & at_max) | (~UP & at_zero));

  // Boundary tests come before any +1/-1 so the count never leaves 0..MAX.
  always_comb begin
    cnt_nxt  = out;
    wrap_nxt = 1'b0;
    if (LOAD) begin
      cnt_nxt = clamp_load(DIN);
    end else if (EN) begin
      if (UP) begin
        if (!at_max) begin
          cnt_nxt = out + ONE;
        end else if (!SAT) begin
          cnt_nxt  = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          cnt_nxt = out - ONE;
        end else if (!SAT) begin
          cnt_nxt  = MAXV;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out  <= '0;
      WRAP <= 1'b0;
    end else begin
      out  <= cnt_nxt;
      WRAP <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: default and MAX=9 instances plus a two-digit
// decimal cascade, checked each cycle against a modulo-arithmetic model.
module tb_counter_updown_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2], en[2], up[2], load[2], sat[2];
  logic [3:0] din[2], outv[2];
  logic       tcv[2], wrapv[2];

  int mmax[2] = '{15, 9};
  int mcnt[2];
  bit mwrap[2];
  bit mvalid[2] = '{1'b0, 1'b0};

  logic       c_rst, c_en;
  logic [3:0] lo_out, hi_out;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap;
  int cval;
  bit clw, chw;
  bit cvalid = 1'b0;
  int hw_cnt = 0;
  int base;

  int errors = 0;
  int checks = 0;

  counter_updown_mod #(.WIDTH(4), .MAX(15)) u_def (
    .CLK(clk), .RESET(rst[0]), .EN(en[0]), .UP(up[0]), .LOAD(load[0]),
    .DIN(din[0]), .SAT(sat[0]), .out(outv[0]), .TC(tcv[0]), .WRAP(wrapv[0]));

  counter_updown_mod #(.WIDTH(4), .MAX(9)) u_m9 (
    .CLK(clk), .RESET(rst[1]), .EN(en[1]), .UP(up[1]), .LOAD(load[1]),
    .DIN(din[1]), .SAT(sat[1]), .out(outv[1]), .TC(tcv[1]), .WRAP(wrapv[1]));

  counter_updown_mod #(.WIDTH(4), .MAX(9)) u_lo (
    .CLK(clk), .RESET(c_rst), .EN(c_en), .UP(1'b1), .LOAD(1'b0),
    .DIN(4'd0), .SAT(1'b0), .out(lo_out), .TC(lo_tc), .WRAP(lo_wrap));

  counter_updown_mod #(.WIDTH(4), .MAX(9)) u_hi (
    .CLK(clk), .RESET(c_rst), .EN(lo_tc), .UP(1'b1), .LOAD(1'b0),
    .DIN(4'd0), .SAT(1'b0), .out(hi_out), .TC(hi_tc), .WRAP(hi_wrap));

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: counting is arithmetic modulo MAX+1, saturation refuses to leave the range.
  task automatic model_update();
    int raw;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        mcnt[i] = 0; mwrap[i] = 1'b0; mvalid[i] = 1'b1;
      end else if (load[i]) begin
        mcnt[i] = (int'(din[i]) > mmax[i]) ? mmax[i] : int'(din[i]);
        mwrap[i] = 1'b0;
      end else if (en[i]) begin
        raw = mcnt[i] + (up[i] ? 1 : -1);
        if (raw < 0 || raw > mmax[i]) begin
          if (sat[i]) mwrap[i] = 1'b0;
          else begin
            mcnt[i] = (raw + mmax[i] + 1) % (mmax[i] + 1);
            mwrap[i] = 1'b1;
          end
        end else begin
          mcnt[i] = raw; mwrap[i] = 1'b0;
        end
      end else begin
        mwrap[i] = 1'b0;
      end
    end
    if (c_rst) begin
      cval = 0; clw = 1'b0; chw = 1'b0; cvalid = 1'b1;
    end else if (c_en) begin
      clw = (cval % 10 == 9);
      chw = (cval == 99);
      cval = (cval + 1) % 100;
    end else begin
      clw = 1'b0; chw = 1'b0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      if (mvalid[i]) begin
        check($sformatf("out[%0d]", i), int'(outv[i]), mcnt[i]);
        check($sformatf("wrap[%0d]", i), int'(wrapv[i]), int'(mwrap[i]));
        check($sformatf("tc[%0d]", i), int'(tcv[i]),
              (en[i] && (up[i] ? (mcnt[i] == mmax[i]) : (mcnt[i] == 0))) ? 1 : 0);
      end
    end
    if (cvalid) begin
      check("casc lo", int'(lo_out), cval % 10);
      check("casc hi", int'(hi_out), cval / 10);
      check("casc lo_tc", int'(lo_tc), (c_en && (cval % 10 == 9)) ? 1 : 0);
      check("casc hi_tc", int'(hi_tc), (c_en && (cval == 99)) ? 1 : 0);
      check("casc lo_wrap", int'(lo_wrap), int'(clw));
      check("casc hi_wrap", int'(hi_wrap), int'(chw));
      if (hi_wrap) hw_cnt++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #2;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; up[i] = 1'b1; load[i] = 1'b0; sat[i] = 1'b0; din[i] = 4'd0;
    end
    c_rst = 1'b1; c_en = 1'b0;
    step(); step();
    check("lit reset out0", int'(outv[0]), 0);
    check("lit reset wrap0", int'(wrapv[0]), 0);

    // Default instance counts up with wrap, MAX=9 instance counts down with wrap.
    rst[0] = 1'b0; en[0] = 1'b1; up[0] = 1'b1; sat[0] = 1'b0;
    rst[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b0; sat[1] = 1'b0;
    c_rst = 1'b0;
    step();
    check("lit up out0", int'(outv[0]), 1);
    check("lit dn out1", int'(outv[1]), 9);
    check("lit dn wrap1", int'(wrapv[1]), 1);
    repeat (14) step();
    check("lit up out0=15", int'(outv[0]), 15);
    check("lit tc0 at 15", int'(tcv[0]), 1);
    check("lit dn out1=5", int'(outv[1]), 5);
    step();
    check("lit wrap out0", int'(outv[0]), 0);
    check("lit wrap0 pulse", int'(wrapv[0]), 1);
    check("lit dn out1=4", int'(outv[1]), 4);
    repeat (4) step();
    check("lit out0=4", int'(outv[0]), 4);
    check("lit wrap0 clear", int'(wrapv[0]), 0);
    check("lit out1=0", int'(outv[1]), 0);
    check("lit tc1 at 0", int'(tcv[1]), 1);

    // Saturation at the top, then reverse direction.
    load[0] = 1'b1; din[0] = 4'd13;
    step();
    check("lit load13", int'(outv[0]), 13);
    load[0] = 1'b0; sat[0] = 1'b1;
    step();
    check("lit sat 14", int'(outv[0]), 14);
    step();
    check("lit sat 15", int'(outv[0]), 15);
    repeat (2) step();
    check("lit sat hold", int'(outv[0]), 15);
    check("lit sat nowrap", int'(wrapv[0]), 0);
    check("lit sat tc", int'(tcv[0]), 1);
    up[0] = 1'b0;
    #1;
    check("lit tc drop on UP=0", int'(tcv[0]), 0);
    step();
    check("lit sat dn 14", int'(outv[0]), 14);
    step();
    check("lit sat dn 13", int'(outv[0]), 13);

    // Load priority and clamping on the MAX=9 instance.
    load[1] = 1'b1; din[1] = 4'd5; en[1] = 1'b1; up[1] = 1'b1;
    step();
    check("lit load5 no count", int'(outv[1]), 5);
    din[1] = 4'd12;
    step();
    check("lit load clamp", int'(outv[1]), 9);
    din[1] = 4'd7; rst[1] = 1'b1;
    step();
    check("lit load+reset", int'(outv[1]), 0);
    rst[1] = 1'b0; load[1] = 1'b0;

    // Reset in the middle of counting.
    sat[0] = 1'b0; up[0] = 1'b1; load[0] = 1'b1; din[0] = 4'd6;
    step();
    load[0] = 1'b0;
    step();
    check("lit pre-reset 7", int'(outv[0]), 7);
    rst[0] = 1'b1;
    step();
    check("lit midreset out", int'(outv[0]), 0);
    check("lit midreset wrap", int'(wrapv[0]), 0);
    rst[0] = 1'b0;
    step();
    check("lit resume 1", int'(outv[0]), 1);

    // Two-digit decimal cascade: 100 edges from reset.
    c_rst = 1'b1; c_en = 1'b1;
    step();
    c_rst = 1'b0;
    base = hw_cnt;
    repeat (99) step();
    check("lit casc 99 lo", int'(lo_out), 9);
    check("lit casc 99 hi", int'(hi_out), 9);
    check("lit casc no hi wrap yet", hw_cnt - base, 0);
    step();
    check("lit casc 00 lo", int'(lo_out), 0);
    check("lit casc 00 hi", int'(hi_out), 0);
    check("lit casc hi wrap", int'(hi_wrap), 1);
    step();
    check("lit casc hi wrap count", hw_cnt - base, 1);

    // Randomised operation on all instances.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i]  = ($urandom_range(0, 49) == 0);
        load[i] = ($urandom_range(0, 9) == 0);
        en[i]   = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) up[i] = ~up[i];
        if ($urandom_range(0, 31) == 0) sat[i] = ~sat[i];
        din[i]  = 4'($urandom_range(0, 15));
      end
      c_rst = ($urandom_range(0, 199) == 0);
      c_en  = ($urandom_range(0, 3) != 0);
      step();
    end
    @(negedge clk);
    compare_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
